volt_sweep_ctrl: RTL and testbench

Sweep sequencer that drives the opcode input of the DAC code counter and consumes its count.
- Per code: clears or steps the counter, triggers a DAC write, waits a settle time, then triggers an ADC conversion.
- Each captured sample is framed into bytes for the UART transmitter over a valid/ready handshake.
- Sits between the DAC driver, the ADC driver, the counter and the UART TX inside the dac/adc/tx IP.

---
 rtl/volt_sweep_ctrl_pkg.sv | 36 +++
 rtl/volt_sweep_ctrl_settle_timer.sv | 45 ++++
 rtl/volt_sweep_ctrl.sv | 171 +++++++++++++++++
 tb/tb_volt_sweep_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/volt_sweep_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// volt_sweep_ctrl_pkg
//   Constants shared by the sweep sequencer and the DAC code counter:
//   - counter opcodes (OPC_*) driven on opc1_o / decoded by the counter
//   - sweep FSM state encoding (ST_*)
//   - settle_cnt_w(): width of the settle down-counter for a given settle time
// ----------------------------------------------------------------------------
package volt_sweep_ctrl_pkg;

    // Counter opcodes. 2'b11 is decoded by the counter as clear as well.
    localparam logic [1:0] OPC_CLEAR = 2'b00;
    localparam logic [1:0] OPC_HOLD  = 2'b01;
    localparam logic [1:0] OPC_INC   = 2'b10;

    // Sweep FSM state encoding.
    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_CLEAR    = 4'd1;
    localparam logic [3:0] ST_DAC_WR   = 4'd2;
    localparam logic [3:0] ST_DAC_WAIT = 4'd3;
    localparam logic [3:0] ST_SETTLE   = 4'd4;
    localparam logic [3:0] ST_ADC_CONV = 4'd5;
    localparam logic [3:0] ST_ADC_WAIT = 4'd6;
    localparam logic [3:0] ST_TX_TAG   = 4'd7;
    localparam logic [3:0] ST_TX_HI    = 4'd8;
    localparam logic [3:0] ST_TX_LO    = 4'd9;
    localparam logic [3:0] ST_CHECK    = 4'd10;
    localparam logic [3:0] ST_STEP     = 4'd11;
    localparam logic [3:0] ST_FINISH   = 4'd12;

    // The settle counter holds values 0..cycles-1; keep at least one bit so
    // the timer is still legal when the settle phase is skipped.
    function automatic int settle_cnt_w(input int cycles);
        return (cycles <= 1) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/volt_sweep_ctrl_settle_timer.sv
// ----------------------------------------------------------------------------
// sweep_settle_timer
//   Loadable down-counter with zero flag, used to time the SETTLE phase.
//   Ports:
//     clk_i       in   clock, rising edge
//     rst_i       in   asynchronous active-high reset (counter -> 0)
//     load_i      in   load load_val_i (has priority over en_i)
//     en_i        in   decrement while non-zero
//     load_val_i  in   CntWidth value to load
//     zero_o      out  counter is zero
// ----------------------------------------------------------------------------
module sweep_settle_timer #(
    parameter int CntWidth = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                load_i,
    input  logic                en_i,
    input  logic [CntWidth-1:0] load_val_i,
    output logic                zero_o
);

    logic [CntWidth-1:0] cnt_q;
    logic [CntWidth-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/volt_sweep_ctrl.sv
// ----------------------------------------------------------------------------
// volt_sweep_ctrl
//   Voltage sweep sequencer. For every counter code it clears/steps the
//   external code counter, fires a DAC write, waits a settle time, fires an
//   ADC conversion and frames the 16-bit zero-extended sample as bytes
//   (high then low) to the UART transmitter.
//
//   Build option: VOLT_SWEEP_TAG_EN -- when defined, a tag byte carrying the
//   low 8 bits of the current code precedes each sample (3 bytes/sample).
//
//   Ports:
//     clk_i        in   system clock, rising edge
//     rst_i        in   asynchronous active-high reset
//     start_i      in   sweep request (sampled in IDLE only)
//     count_i      in   current counter code (Width)
//     opc1_o       out  counter opcode (00 clear, 01 hold, 10 increment)
//     dac_start_o  out  one-cycle DAC write pulse
//     dac_done_i   in   DAC write complete pulse
//     adc_start_o  out  one-cycle ADC conversion pulse
//     adc_done_i   in   ADC conversion complete pulse (adc_data_i valid)
//     adc_data_i   in   ADC sample (AdcWidth)
//     tx_data_o    out  byte to UART TX
//     tx_valid_o   out  byte valid
//     tx_ready_i   in   UART TX accepts byte
//     busy_o       out  high in every state except IDLE
//     done_o       out  one-cycle pulse at sweep end
//
//   TX handshake: a byte transfers on a rising clk edge where tx_valid_o and
//   tx_ready_i are both high; tx_valid_o/tx_data_o stay stable until then and
//   tx_ready_i alone has no effect.
// ----------------------------------------------------------------------------
module volt_sweep_ctrl
    import volt_sweep_ctrl_pkg::*;
#(
    parameter int Width        = 5,
    parameter int MaxCount     = 31,
    parameter int AdcWidth     = 12,
    parameter int SettleCycles = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [Width-1:0]    count_i,
    output logic [1:0]          opc1_o,
    output logic                dac_start_o,
    input  logic                dac_done_i,
    output logic                adc_start_o,
    input  logic                adc_done_i,
    input  logic [AdcWidth-1:0] adc_data_i,
    output logic [7:0]          tx_data_o,
    output logic                tx_valid_o,
    input  logic                tx_ready_i,
    output logic                busy_o,
    output logic                done_o
);

    localparam logic [Width-1:0] MAX_CODE = Width'(MaxCount);

    localparam int SettleW = settle_cnt_w(SettleCycles);
    localparam logic [SettleW-1:0] SETTLE_LOAD =
        SettleW'((SettleCycles > 0) ? SettleCycles - 1 : 0);

`ifdef VOLT_SWEEP_TAG_EN
    localparam logic [3:0] TX_FIRST = ST_TX_TAG;
`else
    localparam logic [3:0] TX_FIRST = ST_TX_HI;
`endif

    logic [3:0]  state_q;
    logic [3:0]  state_d;
    logic [15:0] sample_q;
    logic [15:0] sample_d;
    logic        settle_load;
    logic        settle_zero;

    // The timer is loaded with SettleCycles-1 on entry to SETTLE and counts
    // down while there, so SETTLE lasts exactly SettleCycles cycles.
    sweep_settle_timer #(
        .CntWidth (SettleW)
    ) u_settle (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (settle_load),
        .en_i       (state_q == ST_SETTLE),
        .load_val_i (SETTLE_LOAD),
        .zero_o     (settle_zero)
    );

    // Next-state logic. In the TX states tx_valid_o is high, so tx_ready_i
    // alone marks a completed handshake there.
    always_comb begin
        state_d     = state_q;
        sample_d    = sample_q;
        settle_load = 1'b0;
        case (state_q)
            ST_IDLE:     if (start_i) state_d = ST_CLEAR;
            ST_CLEAR:    state_d = ST_DAC_WR;
            ST_DAC_WR:   state_d = ST_DAC_WAIT;
            ST_DAC_WAIT: begin
                if (dac_done_i) begin
                    if (SettleCycles == 0) begin
                        state_d = ST_ADC_CONV;
                    end else begin
                        state_d     = ST_SETTLE;
                        settle_load = 1'b1;
                    end
                end
            end
            ST_SETTLE:   if (settle_zero) state_d = ST_ADC_CONV;
            ST_ADC_CONV: state_d = ST_ADC_WAIT;
            ST_ADC_WAIT: begin
                if (adc_done_i) begin
                    sample_d = 16'(adc_data_i);
                    state_d  = TX_FIRST;
                end
            end
            ST_TX_TAG:   if (tx_ready_i) state_d = ST_TX_HI;
            ST_TX_HI:    if (tx_ready_i) state_d = ST_TX_LO;
            ST_TX_LO:    if (tx_ready_i) state_d = ST_CHECK;
            // count_i already reflects the last CLEAR/STEP, so the last code
            // is detected here and the counter is never stepped past it.
            ST_CHECK:    state_d = (count_i == MAX_CODE) ? ST_FINISH : ST_STEP;
            ST_STEP:     state_d = ST_DAC_WR;
            ST_FINISH:   state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            sample_q <= '0;
        end else begin
            state_q  <= state_d;
            sample_q <= sample_d;
        end
    end

    // Moore output decode.
    always_comb begin
        opc1_o      = OPC_HOLD;
        dac_start_o = 1'b0;
        adc_start_o = 1'b0;
        tx_data_o   = 8'h00;
        tx_valid_o  = 1'b0;
        done_o      = 1'b0;
        case (state_q)
            ST_CLEAR:    opc1_o      = OPC_CLEAR;
            ST_STEP:     opc1_o      = OPC_INC;
            ST_DAC_WR:   dac_start_o = 1'b1;
            ST_ADC_CONV: adc_start_o = 1'b1;
            ST_TX_TAG: begin
                tx_data_o  = 8'(count_i);
                tx_valid_o = 1'b1;
            end
            ST_TX_HI: begin
                tx_data_o  = sample_q[15:8];
                tx_valid_o = 1'b1;
            end
            ST_TX_LO: begin
                tx_data_o  = sample_q[7:0];
                tx_valid_o = 1'b1;
            end
            ST_FINISH:   done_o      = 1'b1;
            default:     ;
        endcase
    end

    assign busy_o = (state_q != ST_IDLE);

endmodule

// File: tb/tb_volt_sweep_ctrl.sv
`timescale 1ns/1ps
module tb_volt_sweep_ctrl;

    localparam int W     = 5;
    localparam int AW    = 12;
    localparam int MAX_A = 3;
    localparam int SET_A = 4;
    localparam int MAX_B = 0;
    localparam int SET_B = 0;
`ifdef VOLT_SWEEP_TAG_EN
    localparam int         BPS        = 3;
    localparam logic [7:0] FIRST_BYTE = 8'h00;
`else
    localparam int         BPS        = 2;
    localparam logic [7:0] FIRST_BYTE = 8'h0A;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    initial forever #5 clk = ~clk;

    // ---------------- DUT A (MaxCount=3, SettleCycles=4) ----------------
    logic          start_a    = 1'b0;
    logic [W-1:0]  cnt_a      = '1;
    logic [W-1:0]  cnt_nxt_a  = '1;
    logic [1:0]    opc_a;
    logic          dac_start_a;
    logic          dac_done_a = 1'b0;
    logic          adc_start_a;
    logic          adc_done_a = 1'b0;
    logic [AW-1:0] adc_data_a = '0;
    logic [7:0]    tx_data_a;
    logic          tx_valid_a;
    logic          tx_ready_a = 1'b0;
    logic          busy_a;
    logic          done_a;

    // ---------------- DUT B (MaxCount=0, SettleCycles=0) ----------------
    logic          start_b    = 1'b0;
    logic [W-1:0]  cnt_b      = '1;
    logic [W-1:0]  cnt_nxt_b  = '1;
    logic [1:0]    opc_b;
    logic          dac_start_b;
    logic          dac_done_b = 1'b0;
    logic          adc_start_b;
    logic          adc_done_b = 1'b0;
    logic [AW-1:0] adc_data_b = '0;
    logic [7:0]    tx_data_b;
    logic          tx_valid_b;
    logic          tx_ready_b = 1'b0;
    logic          busy_b;
    logic          done_b;

    volt_sweep_ctrl #(.Width(W), .MaxCount(MAX_A), .AdcWidth(AW), .SettleCycles(SET_A)) dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(start_a), .count_i(cnt_a), .opc1_o(opc_a),
        .dac_start_o(dac_start_a), .dac_done_i(dac_done_a),
        .adc_start_o(adc_start_a), .adc_done_i(adc_done_a), .adc_data_i(adc_data_a),
        .tx_data_o(tx_data_a), .tx_valid_o(tx_valid_a), .tx_ready_i(tx_ready_a),
        .busy_o(busy_a), .done_o(done_a)
    );

    volt_sweep_ctrl #(.Width(W), .MaxCount(MAX_B), .AdcWidth(AW), .SettleCycles(SET_B)) dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start_b), .count_i(cnt_b), .opc1_o(opc_b),
        .dac_start_o(dac_start_b), .dac_done_i(dac_done_b),
        .adc_start_o(adc_start_b), .adc_done_i(adc_done_b), .adc_data_i(adc_data_b),
        .tx_data_o(tx_data_b), .tx_valid_o(tx_valid_b), .tx_ready_i(tx_ready_b),
        .busy_o(busy_b), .done_o(done_b)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    logic [1:0] opc_q[$];
    int bytes_a = 0, bytes_b = 0;
    int done_cnt_a = 0, done_cnt_b = 0;
    int t_dac_a = -100, t_dac_b = -100;
    logic dac_pend_a = 1'b0, adc_pend_a = 1'b0, spur_a = 1'b0;
    logic dac_pend_b = 1'b0, adc_pend_b = 1'b0;
    logic [AW-1:0] sample_a = 12'hABC;
    logic [AW-1:0] sample_b = 12'h5A5;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] ctr_next(input logic [1:0] opc, input logic [W-1:0] c);
        case (opc)
            2'b10:   return c + 1'b1;
            2'b01:   return c;
            default: return '0;
        endcase
    endfunction

    task automatic push_sample(inout logic [7:0] q[$], input logic [W-1:0] code,
                               input logic [AW-1:0] smp);
        logic [15:0] s16;
        s16 = 16'(smp);
`ifdef VOLT_SWEEP_TAG_EN
        q.push_back(8'(code));
`endif
        q.push_back(s16[15:8]);
        q.push_back(s16[7:0]);
    endtask

    // External code counter model: registered, updated by the opcode.
    initial forever begin
        @(posedge clk);
        #1;
        cyc++;
        cnt_a = cnt_nxt_a;
        cnt_b = cnt_nxt_b;
    end

    // DUT A environment: DAC/ADC responders, TX monitor, scoreboard pops.
    initial forever begin
        @(negedge clk);
        cnt_nxt_a = ctr_next(opc_a, cnt_a);
        if (rst) begin
            dac_pend_a = 1'b0; adc_pend_a = 1'b0;
            dac_done_a = 1'b0; adc_done_a = 1'b0;
        end else begin
            if (opc_a != 2'b01) opc_q.push_back(opc_a);
            if (tx_valid_a && tx_ready_a) begin
                bytes_a++;
                check("a_tx_byte_expected", exp_a.size() != 0, 1);
                if (exp_a.size() != 0) check("a_tx_byte", tx_data_a, exp_a.pop_front());
            end
            if (done_a) done_cnt_a++;
            dac_done_a = dac_pend_a;
            if (dac_done_a) t_dac_a = cyc;
            dac_pend_a = dac_start_a;
            if (adc_start_a) check("a_settle_latency", cyc - t_dac_a, SET_A + 1);
            adc_done_a = adc_pend_a;
            if (adc_pend_a) begin
                adc_data_a = sample_a;
                push_sample(exp_a, cnt_a, sample_a);
            end else if (spur_a && dac_done_a) begin
                adc_done_a = 1'b1;       // stray conversion pulse in DAC_WAIT
                adc_data_a = '1;
            end else begin
                adc_data_a = AW'($urandom);
            end
            adc_pend_a = adc_start_a;
        end
    end

    // DUT B environment.
    initial forever begin
        @(negedge clk);
        cnt_nxt_b = ctr_next(opc_b, cnt_b);
        if (rst) begin
            dac_pend_b = 1'b0; adc_pend_b = 1'b0;
            dac_done_b = 1'b0; adc_done_b = 1'b0;
        end else begin
            if (tx_valid_b && tx_ready_b) begin
                bytes_b++;
                check("b_tx_byte_expected", exp_b.size() != 0, 1);
                if (exp_b.size() != 0) check("b_tx_byte", tx_data_b, exp_b.pop_front());
            end
            if (done_b) done_cnt_b++;
            dac_done_b = dac_pend_b;
            if (dac_done_b) t_dac_b = cyc;
            dac_pend_b = dac_start_b;
            if (adc_start_b) check("b_settle_latency", cyc - t_dac_b, SET_B + 1);
            adc_done_b = adc_pend_b;
            if (adc_pend_b) begin
                adc_data_b = sample_b;
                push_sample(exp_b, cnt_b, sample_b);
            end else begin
                adc_data_b = AW'($urandom);
            end
            adc_pend_b = adc_start_b;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check_idle_a(input string tag);
        check(tag, {opc_a, dac_start_a, adc_start_a, tx_valid_a, tx_data_a, busy_a, done_a},
              {2'b01, 13'd0});
    endtask

    task automatic check_idle_b(input string tag);
        check(tag, {opc_b, dac_start_b, adc_start_b, tx_valid_b, tx_data_b, busy_b, done_b},
              {2'b01, 13'd0});
    endtask

    task automatic pulse_start_a();
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
    endtask

    task automatic wait_done_a(input int target, input int budget);
        for (int i = 0; i < budget && done_cnt_a < target; i++) begin
            @(posedge clk); #1;
        end
        check("a_done_reached", done_cnt_a >= target, 1);
    endtask

    task automatic wait_done_b(input int target, input int budget);
        for (int i = 0; i < budget && done_cnt_b < target; i++) begin
            @(posedge clk); #1;
        end
        check("b_done_reached", done_cnt_b >= target, 1);
    endtask

    task automatic wait_valid_a(input int budget);
        for (int i = 0; i < budget && !tx_valid_a; i++) begin
            @(posedge clk); #1;
        end
        check("a_valid_reached", tx_valid_a, 1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int bytes0;
        int done0;

        repeat (3) @(posedge clk);
        #1;
        check_idle_a("a_reset_outputs");
        check_idle_b("b_reset_outputs");
        rst = 1'b0;
        @(posedge clk); #1;
        check_idle_a("a_idle_after_reset");

        // Sweep 1: full-rate sweep, opcode trace and byte stream.
        tx_ready_a = 1'b1;
        pulse_start_a();
        wait_done_a(1, 500);
        check("a1_bytes", bytes_a, BPS * (MAX_A + 1));
        check("a1_queue_empty", exp_a.size(), 0);
        check("a1_opc_len", opc_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < opc_q.size()) check("a1_opc_trace", opc_q[i], (i == 0) ? 2'b00 : 2'b10);
        end
        check("a1_done_count", done_cnt_a, 1);

        // Sweep 2: backpressure, stray adc_done in DAC_WAIT, start while busy.
        opc_q.delete();
        bytes0     = bytes_a;
        tx_ready_a = 1'b0;
        spur_a     = 1'b1;
        pulse_start_a();
        wait_valid_a(200);
        for (int i = 0; i < 10; i++) begin
            check("bp_valid_held", tx_valid_a, 1);
            check("bp_data_held", tx_data_a, FIRST_BYTE);
            start_a = (i == 4);
            @(posedge clk); #1;
        end
        start_a = 1'b0;
        check("bp_no_accept", bytes_a, bytes0);
        tx_ready_a = 1'b1;
        wait_done_a(2, 500);
        spur_a = 1'b0;
        check("a2_bytes", bytes_a - bytes0, BPS * (MAX_A + 1));
        check("a2_queue_empty", exp_a.size(), 0);
        repeat (5) @(posedge clk);
        #1;
        check("a2_no_restart", {busy_a, 8'(done_cnt_a)}, {1'b0, 8'd2});

        // Sweep 3: reset while stalled in TX_LO.
        tx_ready_a = 1'b0;
        pulse_start_a();
        wait_valid_a(200);
        repeat (BPS - 1) begin
            tx_ready_a = 1'b1;
            @(posedge clk); #1;
        end
        tx_ready_a = 1'b0;
        check("a3_in_tx_lo", {tx_valid_a, tx_data_a}, {1'b1, 8'hBC});
        done0  = done_cnt_a;
        bytes0 = bytes_a;
        #2 rst = 1'b1;
        #1;
        check_idle_a("a3_reset_mid_tx_lo");
        @(posedge clk); #1;
        rst = 1'b0;
        exp_a.delete();
        repeat (20) @(posedge clk);
        #1;
        check("a3_no_done", done_cnt_a, done0);
        check("a3_no_bytes", bytes_a, bytes0);
        check_idle_a("a3_idle_after_abort");

        // DUT B: single-sample sweeps with no settle phase; start held high
        // so each FINISH rolls straight into another sweep.
        tx_ready_b = 1'b1;
        check_idle_b("b_idle_before_start");
        start_b = 1'b1;
        wait_done_b(3, 300);
        start_b = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("b_done_count", done_cnt_b, 3);
        check("b_bytes", bytes_b, 3 * BPS);
        check("b_queue_empty", exp_b.size(), 0);
        check_idle_b("b_idle_after_sweeps");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "global timeout");
    end

endmodule
